unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter and sequencer for the single unified instruction/data memory. It shares the one memory port between the instruction-fetch requester and the data (load/store) requester, grants at most one access per cycle, and generates per-requester stall signals for the pipeline. It registers read responses and guards instruction fetch against starvation under sustained data traffic.

## Interface
Parameters:
- `PRIORITY_MODE`, default 0: 0 = data priority with starvation guard; 1 = round-robin.
- `STARVE_LIMIT`, default 4: consecutive denied fetch cycles before fetch is forced to win (mode 0 only); 0 disables the guard.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `if_req` in 1: fetch request.
- `if_addr` in 32: fetch byte address.
- `if_gnt` out 1: fetch granted this cycle.
- `if_stall` out 1: `if_req & ~if_gnt`.
- `if_rvalid` out 1: fetch data valid (one-cycle pulse).
- `if_rdata` out 32: registered fetch word.
- `d_req` in 1: data request.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in 32: data byte address.
- `d_func3` in 3: access size/sign code, passed through to memory.
- `d_wdata` in 32: store data.
- `d_gnt` out 1: data granted this cycle.
- `d_stall` out 1: `d_req & ~d_gnt`.
- `d_rvalid` out 1: data access complete (one-cycle pulse, loads and stores).
- `d_rdata` out 32: registered load data.
- `mem_read` out 1: memory read enable.
- `mem_write` out 1: memory write enable.
- `mem_addr` out 32: memory address.
- `mem_func3` out 3: memory func3.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory combinational read data.

## Operation
- **Grant decision** (combinational, from current requests and registered state):
  - Only one requester active: that requester is granted.
  - Both active, mode 0: data wins, unless `STARVE_LIMIT != 0` and `starve_cnt == STARVE_LIMIT`, in which case fetch wins.
  - Both active, mode 1: the requester that was not `last_owner` wins.
  - While `rst` is low, both grants are forced to 0.
- **Memory drive**:
  - Fetch grant: `mem_read = 1`, `mem_write = 0`, `mem_addr = if_addr`, `mem_func3 = 3'b010`, `mem_wdata = 0`.
  - Data grant: `mem_read = ~d_we`, `mem_write = d_we`; address, func3 and wdata come from the data port.
  - No grant: all memory outputs 0.
- **starve_cnt**: increments when `if_req & ~if_gnt`, saturating at `STARVE_LIMIT`. Cleared when `if_gnt` is high or `if_req` is low.
- **last_owner**: one bit, updated to the granted requester on every grant; held when nothing is granted.
- **Response registers**:
  - Fetch grant: `if_rdata <= mem_rdata`, `if_rvalid <= 1`.
  - Data load grant: `d_rdata <= mem_rdata`, `d_rvalid <= 1`.
  - Data store grant: `d_rvalid <= 1`, `d_rdata` is held.
  - Ungranted: the rvalid drops to 0 and the rdata is held.
- **Requester rule**: a requester holds `req`, address, func3, we and wdata stable until it sees its grant. The arbiter does not latch request fields.

## Timing
- Grant is in the same cycle as the request when uncontended (zero-cycle arbitration).
- A store is written at the rising edge that ends its grant cycle.
- Read data and rvalid appear in the cycle after the grant (latency 1). Throughput is one access per cycle total; back-to-back grants to the same requester are allowed.
- **Reset** (`rst` low at a rising edge):
  - Cleared: `starve_cnt = 0`, `if_rvalid = 0`, `d_rvalid = 0`, `if_rdata = 0`, `d_rdata = 0`.
  - `last_owner` is set to data, so the first contended round-robin grant goes to fetch.
  - Combinational outputs are 0 while reset is asserted.
- **Reset mid-operation**: a grant issued in the cycle before reset produces no rvalid in the reset cycle. A store that was granted before reset remains written.
- **Simultaneous requests at saturation**: fetch wins, and `starve_cnt` clears at that edge.
- **Addresses**: passed through unmodified. No alignment or range checking.

## Test plan
- **Reset**: hold `rst` = 0 for 2 cycles with both requests high -> `if_gnt = d_gnt = 0`, `mem_read = mem_write = 0`, both rvalid 0; after release, first grant goes to data (mode 0).
- **Fetch only**: `if_addr = 0x10`, memory word `0x00500093` -> `if_gnt` in the same cycle, `mem_func3 = 010`; next cycle `if_rvalid = 1` and `if_rdata = 0x00500093`.
- **Starvation guard**: mode 0, `STARVE_LIMIT = 4`, both requesting loads continuously -> `d_gnt` for 4 cycles, `if_gnt` on the 5th, `if_stall` high for cycles 1-4; the 4:1 pattern repeats.
- **Store then load**: store with `func3 = 000`, `addr = 0x20`, `wdata = 0xAB` -> `mem_write` for one cycle and `d_rvalid` on the next. A following load with `func3 = 000` at `0x20` -> `d_rdata = 0xFFFFFFAB`.
- **Round-robin**: mode 1, both requesting continuously after reset -> grants alternate IF, D, IF, D; each rvalid pulses on alternate cycles.
- **Reset mid-operation**: fetch granted at cycle N, `rst` low during cycle N+1 -> `if_rvalid = 0` in cycle N+1 and `starve_cnt = 0`.

Source files
------------

// File: rtl/unified_mem_arbiter_if.sv
// Port bundle for the unified memory arbiter: fetch requester, data requester
// and the single memory port. The arbiter takes the slave side.
interface unified_mem_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_gnt;
   logic        if_stall;
   logic        if_rvalid;
   logic [31:0] if_rdata;

   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [2:0]  d_func3;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_stall;
   logic        d_rvalid;
   logic [31:0] d_rdata;

   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_addr;
   logic [2:0]  mem_func3;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
      output if_gnt, if_stall, if_rvalid, if_rdata,
             d_gnt, d_stall, d_rvalid, d_rdata,
             mem_read, mem_write, mem_addr, mem_func3, mem_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_func3, d_wdata, mem_rdata,
      input  if_gnt, if_stall, if_rvalid, if_rdata,
             d_gnt, d_stall, d_rvalid, d_rdata,
             mem_read, mem_write, mem_addr, mem_func3, mem_wdata
   );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store: same-cycle
// grant, one-cycle registered responses, fetch starvation guard or round-robin.
module unified_mem_arbiter #(
   parameter int PRIORITY_MODE = 0,
   parameter int STARVE_LIMIT  = 4
) (
   input logic                  clk,
   input logic                  rst,
   unified_mem_arbiter_if.slave bus
);
   localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT_W = CW'(STARVE_LIMIT);

   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_e;

   owner_e        last_owner;
   logic [CW-1:0] starve_cnt;
   logic          starved;
   logic          fetch_wins;
   logic          if_gnt_c;
   logic          d_gnt_c;
   logic          if_rvalid_q;
   logic          d_rvalid_q;
   logic [31:0]   if_rdata_q;
   logic [31:0]   d_rdata_q;

   assign starved = (STARVE_LIMIT != 0) && (starve_cnt == LIMIT_W);

   // Contended winner only; uncontended requests always win outright.
   always_comb begin
      fetch_wins = 1'b0;
      if (PRIORITY_MODE == 1) fetch_wins = (last_owner == OWN_D);
      else                    fetch_wins = starved;
   end

   always_comb begin
      if_gnt_c = 1'b0;
      d_gnt_c  = 1'b0;
      if (rst) begin
         if (bus.if_req && bus.d_req) begin
            if_gnt_c = fetch_wins;
            d_gnt_c  = ~fetch_wins;
         end else begin
            if_gnt_c = bus.if_req;
            d_gnt_c  = bus.d_req;
         end
      end
   end

   always_comb begin
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_func3 = '0;
      bus.mem_wdata = '0;
      if (if_gnt_c) begin
         bus.mem_read  = 1'b1;
         bus.mem_addr  = bus.if_addr;
         bus.mem_func3 = 3'b010;
      end else if (d_gnt_c) begin
         bus.mem_read  = ~bus.d_we;
         bus.mem_write = bus.d_we;
         bus.mem_addr  = bus.d_addr;
         bus.mem_func3 = bus.d_func3;
         bus.mem_wdata = bus.d_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         starve_cnt  <= '0;
         last_owner  <= OWN_D;
         if_rvalid_q <= 1'b0;
         d_rvalid_q  <= 1'b0;
         if_rdata_q  <= '0;
         d_rdata_q   <= '0;
      end else begin
         if (bus.if_req && !if_gnt_c) begin
            if (starve_cnt != LIMIT_W) starve_cnt <= starve_cnt + CW'(1);
         end else begin
            starve_cnt <= '0;
         end
         if (if_gnt_c)     last_owner <= OWN_IF;
         else if (d_gnt_c) last_owner <= OWN_D;
         if_rvalid_q <= if_gnt_c;
         d_rvalid_q  <= d_gnt_c;
         if (if_gnt_c)              if_rdata_q <= bus.mem_rdata;
         if (d_gnt_c && !bus.d_we)  d_rdata_q  <= bus.mem_rdata;
      end
   end

   // Responses to a grant just before reset must not surface during reset.
   assign bus.if_rvalid = if_rvalid_q & rst;
   assign bus.d_rvalid  = d_rvalid_q & rst;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.if_gnt    = if_gnt_c;
   assign bus.d_gnt     = d_gnt_c;
   assign bus.if_stall  = bus.if_req & ~if_gnt_c & rst;
   assign bus.d_stall   = bus.d_req & ~d_gnt_c & rst;
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Three arbiters (data priority, round-robin, guard disabled) driven by the same
// directed and random traffic, checked against a per-instance reference model.
module tb_unified_mem_arbiter;
   localparam int NI = 3;

   typedef struct {
      int          due;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   logic [NI-1:0]        if_req, d_req, d_we;
   logic [NI-1:0][31:0]  if_addr, d_addr, d_wdata;
   logic [NI-1:0][2:0]   d_func3;
   logic [NI-1:0]        ob_if_gnt, ob_d_gnt, ob_if_rvalid, ob_d_rvalid;
   logic [NI-1:0][31:0]  ob_if_rdata, ob_d_rdata;

   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, inst, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] load_fmt(input logic [31:0] w, input logic [2:0] f3);
      case (f3)
         3'b000:  load_fmt = {{24{w[7]}}, w[7:0]};
         3'b001:  load_fmt = {{16{w[15]}}, w[15:0]};
         3'b100:  load_fmt = {24'h0, w[7:0]};
         3'b101:  load_fmt = {16'h0, w[15:0]};
         default: load_fmt = w;
      endcase
   endfunction

   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
   endfunction

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int MODE = (g == 1) ? 1 : 0;
      localparam int LIM  = (g == 2) ? 0 : 4;

      unified_mem_arbiter_if bus ();

      unified_mem_arbiter #(.PRIORITY_MODE(MODE), .STARVE_LIMIT(LIM)) u_dut (
         .clk (clk),
         .rst (rst),
         .bus (bus)
      );

      assign bus.if_req  = if_req[g];
      assign bus.if_addr = if_addr[g];
      assign bus.d_req   = d_req[g];
      assign bus.d_we    = d_we[g];
      assign bus.d_addr  = d_addr[g];
      assign bus.d_func3 = d_func3[g];
      assign bus.d_wdata = d_wdata[g];
      assign ob_if_gnt[g]    = bus.if_gnt;
      assign ob_d_gnt[g]     = bus.d_gnt;
      assign ob_if_rvalid[g] = bus.if_rvalid;
      assign ob_d_rvalid[g]  = bus.d_rvalid;
      assign ob_if_rdata[g]  = bus.if_rdata;
      assign ob_d_rdata[g]   = bus.d_rdata;

      logic [7:0]  env_mem [256];
      logic [7:0]  ref_mem [256];
      exp_t        ifq[$];
      exp_t        dq[$];
      int          denied = 0;
      bit          last_d = 1'b1;
      logic [31:0] d_hold = '0;

      initial begin
         for (int k = 0; k < 256; k++) begin
            env_mem[k] = 8'($urandom);
            ref_mem[k] = env_mem[k];
         end
         env_mem[16] = 8'h93; env_mem[17] = 8'h00; env_mem[18] = 8'h50; env_mem[19] = 8'h00;
         ref_mem[16] = 8'h93; ref_mem[17] = 8'h00; ref_mem[18] = 8'h50; ref_mem[19] = 8'h00;
      end

      // Memory behaviour seen by the DUT, driven only from the DUT's memory port.
      initial forever begin : rd_drv
         logic [7:0] b;
         @(posedge clk);
         #2;
         b = bus.mem_addr[7:0];
         bus.mem_rdata = load_fmt({env_mem[b + 8'd3], env_mem[b + 8'd2], env_mem[b + 8'd1], env_mem[b]},
                                  bus.mem_func3);
      end

      initial forever begin : wr_cap
         logic [7:0] b;
         @(negedge clk);
         if (bus.mem_write === 1'b1) begin
            b = bus.mem_addr[7:0];
            for (int k = 0; k < nbytes(bus.mem_func3); k++)
               env_mem[b + 8'(k)] = bus.mem_wdata[8*k +: 8];
         end
      end

      // Reference model: decides the winner from the arbitration rules, checks the
      // combinational outputs and queues the responses expected one cycle later.
      initial forever begin : model
         bit          ig, dg;
         logic [7:0]  a;
         exp_t        e;
         @(negedge clk);
         ig = 1'b0;
         dg = 1'b0;
         if (rst) begin
            if (if_req[g] && d_req[g]) begin
               ig = (MODE == 1) ? last_d : (LIM != 0 && denied == LIM);
               dg = !ig;
            end else begin
               ig = if_req[g];
               dg = d_req[g];
            end
         end
         check("if_gnt",   g, 32'(bus.if_gnt),   32'(ig));
         check("d_gnt",    g, 32'(bus.d_gnt),    32'(dg));
         check("if_stall", g, 32'(bus.if_stall), 32'(rst & if_req[g] & !ig));
         check("d_stall",  g, 32'(bus.d_stall),  32'(rst & d_req[g] & !dg));
         check("mem_read",  g, 32'(bus.mem_read),  32'(ig | (dg & !d_we[g])));
         check("mem_write", g, 32'(bus.mem_write), 32'(dg & d_we[g]));
         check("mem_addr",  g, bus.mem_addr,  ig ? if_addr[g] : dg ? d_addr[g] : 32'h0);
         check("mem_func3", g, 32'(bus.mem_func3), ig ? 32'd2 : dg ? 32'(d_func3[g]) : 32'd0);
         check("mem_wdata", g, bus.mem_wdata, (dg && !ig) ? d_wdata[g] : 32'h0);
         if (!rst) begin
            denied = 0;
            last_d = 1'b1;
            d_hold = '0;
         end else begin
            denied = (if_req[g] && !ig) ? ((denied < LIM) ? denied + 1 : LIM) : 0;
            if (ig) begin
               last_d = 1'b0;
               a = if_addr[g][7:0];
               e.due  = cyc + 1;
               e.data = {ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]};
               ifq.push_back(e);
            end
            if (dg) begin
               last_d = 1'b1;
               a = d_addr[g][7:0];
               if (d_we[g]) begin
                  for (int k = 0; k < nbytes(d_func3[g]); k++)
                     ref_mem[a + 8'(k)] = d_wdata[g][8*k +: 8];
               end else begin
                  d_hold = load_fmt({ref_mem[a + 8'd3], ref_mem[a + 8'd2], ref_mem[a + 8'd1], ref_mem[a]},
                                    d_func3[g]);
               end
               e.due  = cyc + 1;
               e.data = d_hold;
               dq.push_back(e);
            end
         end
      end

      initial forever begin : monitor
         bit   exp_v;
         exp_t e;
         @(negedge clk);
         if (!rst) begin
            while (ifq.size() > 0 && ifq[0].due <= cyc) void'(ifq.pop_front());
            while (dq.size() > 0 && dq[0].due <= cyc) void'(dq.pop_front());
         end
         exp_v = ifq.size() > 0 && ifq[0].due == cyc;
         check("if_rvalid", g, 32'(bus.if_rvalid), 32'(exp_v));
         if (exp_v) begin
            e = ifq.pop_front();
            if (bus.if_rvalid) check("if_rdata", g, bus.if_rdata, e.data);
         end
         exp_v = dq.size() > 0 && dq[0].due == cyc;
         check("d_rvalid", g, 32'(bus.d_rvalid), 32'(exp_v));
         if (exp_v) begin
            e = dq.pop_front();
            if (bus.d_rvalid) check("d_rdata", g, bus.d_rdata, e.data);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic ir, input logic [31:0] ia, input logic dr, input logic we,
                          input logic [31:0] da, input logic [2:0] f3, input logic [31:0] wd);
      for (int i = 0; i < NI; i++) begin
         if_req[i]  = ir;  if_addr[i] = ia;
         d_req[i]   = dr;  d_we[i]    = we;
         d_addr[i]  = da;  d_func3[i] = f3;  d_wdata[i] = wd;
      end
   endtask

   logic [NI-1:0][9:0] pat;
   logic [NI-1:0]      ig_s, dg_s;
   logic [2:0]         ldf3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
   logic [31:0]        r, ra;

   initial begin
      rst = 1'b0;
      set_all(1'b1, 32'h14, 1'b1, 1'b0, 32'h40, 3'b010, 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b1;

      // Continuous contention: 4:1 data/fetch, alternating, or fetch starved.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         for (int k = 0; k < NI; k++) pat[k][i] = ob_if_gnt[k];
         if (i == 0) check("first_grant_data", 0, 32'(ob_d_gnt[0]), 32'd1);
         next_cycle();
      end
      check("starve_pattern", 0, 32'(pat[0]), 32'h210);
      check("rr_pattern",     1, 32'(pat[1]), 32'h155);
      check("noguard_pattern", 2, 32'(pat[2]), 32'h000);

      set_all(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      next_cycle();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check("fetch_rvalid", k, 32'(ob_if_rvalid[k]), 32'd1);
         check("fetch_rdata",  k, ob_if_rdata[k], 32'h00500093);
      end
      next_cycle();

      set_all(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 3'b000, 32'h000000AB);
      next_cycle();
      set_all(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 3'b000, 32'h0);
      next_cycle();
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("lb_signext", k, ob_d_rdata[k], 32'hFFFFFFAB);
      next_cycle();

      set_all(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NI; k++) check("midrst_if_rvalid", k, 32'(ob_if_rvalid[k]), 32'd0);
      next_cycle();
      rst = 1'b1;

      // Random traffic; requesters hold their request until granted.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         ig_s = ob_if_gnt;
         dg_s = ob_d_gnt;
         next_cycle();
         rst = (c != 200);
         for (int i = 0; i < NI; i++) begin
            if (!(if_req[i] && !ig_s[i])) begin
               r  = $urandom;
               ra = $urandom;
               if_req[i]  = (r[1:0] != 2'b00);
               if_addr[i] = {ra[31:2], 2'b00};
            end
            if (!(d_req[i] && !dg_s[i])) begin
               r  = $urandom;
               ra = $urandom;
               d_req[i] = (r[2:0] > 3'd1);
               d_we[i]  = (r[4:3] == 2'b00);
               if (d_we[i]) d_func3[i] = (r[6:5] == 2'b11) ? 3'b010 : {1'b0, r[6:5]};
               else         d_func3[i] = ldf3[int'(r[9:7]) % 5];
               if (d_func3[i][1:0] == 2'd1) ra[0] = 1'b0;
               if (d_func3[i][1:0] == 2'd2) ra[1:0] = 2'b00;
               d_addr[i]  = ra;
               d_wdata[i] = $urandom;
            end
         end
      end

      @(negedge clk);
      next_cycle();
      rst = 1'b1;
      set_all(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 3'b000, 32'h0);
      repeat (3) @(negedge clk);
      #1;
      check("drain_ifq", 0, 32'(g_dut[0].ifq.size()), 32'd0);
      check("drain_dq",  0, 32'(g_dut[0].dq.size()),  32'd0);
      check("drain_ifq", 1, 32'(g_dut[1].ifq.size()), 32'd0);
      check("drain_dq",  1, 32'(g_dut[1].dq.size()),  32'd0);
      check("drain_ifq", 2, 32'(g_dut[2].ifq.size()), 32'd0);
      check("drain_dq",  2, 32'(g_dut[2].dq.size()),  32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
